// File: rtl/aer_spike_encoder_pkg.sv
// Shared spike-fabric types: encoder FSM states and the default AER event layout.
package snn_pkg;

   localparam int DEF_NUM_NEURONS = 8;
   localparam int DEF_ADDR_W      = $clog2(DEF_NUM_NEURONS);
   localparam int DEF_TS_W        = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_TS_W-1:0]   ts;
   } aer_event_t;

endpackage

// File: rtl/aer_spike_encoder_if.sv
// AER event stream: valid/ready handshake carrying neuron address and timestep stamp.
interface aer_spike_encoder_if
   import snn_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int TS_W   = DEF_TS_W
);

   logic              aer_valid;
   logic              aer_ready;
   logic [ADDR_W-1:0] aer_addr;
   logic [TS_W-1:0]   aer_ts;

   modport master (
      output aer_valid,
      output aer_addr,
      output aer_ts,
      input  aer_ready
   );

   modport slave (
      input  aer_valid,
      input  aer_addr,
      input  aer_ts,
      output aer_ready
   );

endinterface

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-set-bit finder: index, any-set flag and one-hot clear mask.
module spike_priority_encoder #(
   parameter int NUM_NEURONS = 8,
   parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
   input  logic [NUM_NEURONS-1:0] vec,
   output logic [ADDR_W-1:0]      idx,
   output logic                   any_set,
   output logic [NUM_NEURONS-1:0] onehot
);

   always_comb begin
      idx = '0;
      // Scan downwards so the lowest set bit is the last one to win.
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = ADDR_W'(i);
         end
      end
      any_set = |vec;
      onehot  = vec & (~vec + NUM_NEURONS'(1));
   end

endmodule

// File: rtl/aer_spike_encoder.sv
// AER transmitter: captures the spike vector on each step and emits one address event
// per set bit, lowest index first, stamped with the step's timestep.
module aer_spike_encoder
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int ADDR_W      = $clog2(NUM_NEURONS),
   parameter int TS_W        = DEF_TS_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   step,
   input  logic [NUM_NEURONS-1:0] spike_in,
   aer_spike_encoder_if.master    aer,
   output logic                   busy,
   output logic                   step_done,
   output logic                   overrun,
   input  logic                   clear_overrun
);

   state_t                 state, state_nxt;
   logic [NUM_NEURONS-1:0] pending, pending_nxt;
   logic [TS_W-1:0]        ts_cnt, ts_cnt_nxt;
   logic [TS_W-1:0]        cur_ts, cur_ts_nxt;
   logic                   step_done_nxt;
   logic                   overrun_nxt;

   logic [ADDR_W-1:0]      sel_idx;
   logic                   any_set;
   logic [NUM_NEURONS-1:0] sel_mask;
   logic [NUM_NEURONS-1:0] rest;
   logic                   handshake;
   logic                   sending;

   spike_priority_encoder #(
      .NUM_NEURONS (NUM_NEURONS),
      .ADDR_W      (ADDR_W)
   ) u_prio (
      .vec     (pending),
      .idx     (sel_idx),
      .any_set (any_set),
      .onehot  (sel_mask)
   );

   assign sending       = (state == SEND);
   assign aer.aer_valid = sending;
   assign aer.aer_addr  = sending ? sel_idx : '0;
   assign aer.aer_ts    = sending ? cur_ts : '0;
   assign busy          = sending;
   assign handshake     = sending & aer.aer_ready;
   assign rest          = pending & ~sel_mask;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pending   <= '0;
         ts_cnt    <= '0;
         cur_ts    <= '0;
         step_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         ts_cnt    <= ts_cnt_nxt;
         cur_ts    <= cur_ts_nxt;
         step_done <= step_done_nxt;
         overrun   <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pending_nxt   = pending;
      ts_cnt_nxt    = ts_cnt;
      cur_ts_nxt    = cur_ts;
      step_done_nxt = 1'b0;
      overrun_nxt   = overrun;

      // A step landing while a burst is still in flight (even on its last beat) is lost.
      if (step && sending) begin
         overrun_nxt = 1'b1;
      end else if (clear_overrun) begin
         overrun_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            if (step) begin
               pending_nxt = spike_in;
               cur_ts_nxt  = ts_cnt;
               ts_cnt_nxt  = ts_cnt + TS_W'(1);
               if (|spike_in) begin
                  state_nxt = SEND;
               end else begin
                  step_done_nxt = 1'b1;
               end
            end
         end
         SEND: begin
            if (!any_set) begin
               state_nxt = IDLE;
            end else if (handshake) begin
               pending_nxt = rest;
               if (rest == '0) begin
                  state_nxt     = IDLE;
                  step_done_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: directed and random steps checked against a queue-based event model.
module tb_aer_spike_encoder;
   import snn_pkg::*;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int TW = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         step;
   logic [N-1:0] spike_in;
   logic         busy;
   logic         step_done;
   logic         overrun;
   logic         clear_overrun;

   aer_spike_encoder_if #(.ADDR_W(AW), .TS_W(TW)) aer ();

   aer_spike_encoder #(
      .NUM_NEURONS (N),
      .ADDR_W      (AW),
      .TS_W        (TW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .step          (step),
      .spike_in      (spike_in),
      .aer           (aer),
      .busy          (busy),
      .step_done     (step_done),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int ts;
   } ev_t;

   int  vectors     = 0;
   int  miscompares = 0;
   ev_t exp_q[$];
   int  ts_model    = 0;
   bit  done_exp    = 1'b0;
   bit  ovr_exp     = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, drive inputs, advance the model.
   task automatic cycle(input bit stp, input logic [7:0] spk, input bit rdy, input bit clr);
      bit  busy_exp;
      bit  done_nxt;
      ev_t e;
      busy_exp = (exp_q.size() != 0);
      chk("aer_valid", 32'(aer.aer_valid), 32'(busy_exp));
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("step_done", 32'(step_done), 32'(done_exp));
      chk("overrun", 32'(overrun), 32'(ovr_exp));
      if (busy_exp) begin
         chk("aer_addr", 32'(aer.aer_addr), exp_q[0].addr);
         chk("aer_ts", 32'(aer.aer_ts), exp_q[0].ts);
      end
      step          = stp;
      spike_in      = spk;
      aer.aer_ready = rdy;
      clear_overrun = clr;
      done_nxt = 1'b0;
      if (stp && busy_exp) ovr_exp = 1'b1;
      else if (clr)        ovr_exp = 1'b0;
      if (busy_exp && rdy) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) done_nxt = 1'b1;
      end else if (stp && !busy_exp) begin
         for (int i = 0; i < N; i++) begin
            if (spk[i]) begin
               e.addr = i;
               e.ts   = ts_model;
               exp_q.push_back(e);
            end
         end
         if (spk == 8'h00) done_nxt = 1'b1;
         ts_model = (ts_model + 1) % 256;
      end
      done_exp = done_nxt;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " aer_valid"}, 32'(aer.aer_valid), 32'd0);
      chk({tag, " aer_addr"}, 32'(aer.aer_addr), 32'd0);
      chk({tag, " aer_ts"}, 32'(aer.aer_ts), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " step_done"}, 32'(step_done), 32'd0);
      chk({tag, " overrun"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      reset_n       = 1'b0;
      step          = 1'b0;
      spike_in      = '0;
      aer.aer_ready = 1'b0;
      clear_overrun = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Basic burst: addresses 2,5,7 at ts 0.
      cycle(1'b1, 8'b1010_0100, 1'b1, 1'b0);
      repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure: ready low for three valid cycles.
      cycle(1'b1, 8'h03, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Empty step still consumes a timestep.
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h10, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Overrun: second step two cycles into a full burst is dropped.
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h0F, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h01, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Step coinciding with the final handshake is also dropped.
      cycle(1'b1, 8'h01, 1'b1, 1'b0);
      cycle(1'b1, 8'h02, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      // Set and clear together: set wins.
      cycle(1'b1, 8'h80, 1'b1, 1'b0);
      cycle(1'b1, 8'h01, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic.
      repeat (400) begin
         cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 15) == 0);
      end
      repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset during the second event of a full burst, with overrun set.
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      chk("pre-reset overrun", 32'(overrun), 32'd1);
      chk("pre-reset aer_addr", 32'(aer.aer_addr), 32'd1);
      reset_n = 1'b0;
      step    = 1'b0;
      #1;
      check_reset_outputs("midburst reset");
      exp_q.delete();
      ts_model = 0;
      ovr_exp  = 1'b0;
      done_exp = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b1, 8'h08, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Timestamp wrap: ts continues 1..255 then 0, 1.
      repeat (257) begin
         cycle(1'b1, 8'h01, 1'b1, 1'b0);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("wrap ts_model", 32'(ts_model), 32'(ts_model));
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
